// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - round-robin press-pulse arbiter into one valid/ready event stream
// Optional macro EVENT_COUNT_EN: per-button saturating press counters and an event_count port.
module button_event_arbiter #(
  parameter int NUM_BTN = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 3
) (
  input  logic               clk,
  input  logic               rst_s_n,
  input  logic [NUM_BTN-1:0] pulse_in,
  output logic               event_valid,
  input  logic               event_ready,
  output logic [ID_W-1:0]    event_id,
  output logic [NUM_BTN-1:0] pending,
  output logic               overflow
`ifdef EVENT_COUNT_EN
  ,
  output logic [CNT_W-1:0]   event_count
`endif
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t             state;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    win;
  logic               found;
  int                 idx;
  logic               grant;
  logic               ovf_next;
  logic [NUM_BTN-1:0] pend_next;

  // A grant happens whenever something is pending and the output slot is free or being freed.
  assign grant = (|pending) && (state == IDLE || event_ready);

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      idx = (int'(last_grant) + k) % NUM_BTN;
      if (!found && pending[idx]) begin
        found = 1'b1;
        win   = idx[ID_W-1:0];
      end
    end
  end

`ifdef EVENT_COUNT_EN
  logic [CNT_W-1:0] cnt      [NUM_BTN];
  logic [CNT_W-1:0] cnt_next [NUM_BTN];

  always_comb begin
    ovf_next  = 1'b0;
    pend_next = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_next[i] = cnt[i];
      if (grant && win == ID_W'(i)) begin
        cnt_next[i] = pulse_in[i] ? CNT_W'(1) : '0;
      end else if (pulse_in[i]) begin
        if (cnt[i] == '1) ovf_next = 1'b1;
        else              cnt_next[i] = cnt[i] + 1'b1;
      end
      pend_next[i] = (cnt_next[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_s_n) begin
      for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
      event_count <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) cnt[i] <= cnt_next[i];
      if (grant) event_count <= cnt[win];
    end
  end
`else
  // CNT_W only sizes the counters of the counting build.
  logic [CNT_W-1:0] unused_cnt_tie;
  assign unused_cnt_tie = '0;

  always_comb begin
    ovf_next  = 1'b0;
    pend_next = pending;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (grant && win == ID_W'(i)) begin
        pend_next[i] = pulse_in[i];
      end else if (pulse_in[i]) begin
        if (pending[i]) ovf_next = 1'b1;
        pend_next[i] = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_s_n) begin
      state       <= IDLE;
      event_valid <= 1'b0;
      event_id    <= '0;
      pending     <= '0;
      overflow    <= 1'b0;
      last_grant  <= ID_W'(NUM_BTN - 1);
    end else begin
      pending  <= pend_next;
      overflow <= ovf_next;
      if (grant) begin
        state       <= PRESENT;
        event_valid <= 1'b1;
        event_id    <= win;
        last_grant  <= win;
      end else if (state == PRESENT && event_ready) begin
        state       <= IDLE;
        event_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
- Collects single-cycle press pulses from up to NUM_BTN debounced one_shot instances and latches each one as a pending request.
- Grants pending requests round-robin and serialises them into a single valid/ready event stream for the downstream menu/control FSM.
- Sits between the per-button one_shot blocks and the consumer; no button press is lost silently.

Parameters:
- NUM_BTN, 4, number of pulse inputs (2..16).
- ID_W, 2, event_id width; must satisfy 2^ID_W >= NUM_BTN.
- CNT_W, 3, press-count width; used only with EVENT_COUNT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_s_n  in  1  synchronous reset, active low.
- pulse_in  in  NUM_BTN  one-cycle press pulses, one bit per button.
- event_valid  out  1  an event is being presented.
- event_ready  in  1  consumer accepts the event when high with event_valid.
- event_id  out  ID_W  index of the granted button.
- pending  out  NUM_BTN  latched, not-yet-granted requests.
- overflow  out  1  one-cycle pulse: a press was dropped.
- event_count  out  CNT_W  presses merged into the current event; port exists only with EVENT_COUNT_EN.

Behaviour:
- Reset (rst_s_n=0 at a rising edge): pending=0, event_valid=0, event_id=0, overflow=0, last_grant=NUM_BTN-1, state=IDLE. Reset mid-transfer drops the presented event without a handshake.
- Pending latch: pulse_in[i]=1 at edge k sets pending[i] after edge k.
- States: IDLE (event_valid=0) and PRESENT (event_valid=1).
- IDLE: if pending!=0 at edge k, the winner w is loaded into event_id, pending[w] is cleared, last_grant=w, and the block enters PRESENT after edge k.
  - Latency from the pulse edge to event_valid=1 is 2 clocks.
- Winner selection: first set bit of pending, searching from (last_grant+1) mod NUM_BTN upward with wrap. After reset, button 0 has top priority.
- PRESENT: event_id (and event_count) stay stable while event_ready=0.
- Handshake edge (event_valid & event_ready):
  - if pending!=0, the next winner is granted on the same edge and event_valid stays 1 (back-to-back throughput of 1 event/clock);
  - otherwise the block returns to IDLE with event_valid=0.
- Simultaneous pulse_in[w] and grant-clear of w on the same edge: the set wins, pending[w] stays 1 and represents a new press.
- Pulse on an input that is already pending and not being granted that edge: the press is dropped and overflow=1 for exactly the following cycle. One overflow pulse covers any number of such drops on the same edge.
- Pulses on multiple inputs on the same edge each set their own bit, with no loss.
- pulse_in held high for several cycles is treated as repeated pulses, so the second and later cycles produce overflow.
- event_id is zero-extended to ID_W.

Optional Feature:
- Macro: EVENT_COUNT_EN.
- Defined:
  - each input has a CNT_W saturating counter;
  - the first pulse sets the counter to 1;
  - a pulse while pending increments it with no overflow;
  - overflow fires only when a pulse arrives with the counter at 2^CNT_W-1;
  - on grant, the counter value is copied to event_count and the counter is cleared, or set to 1 when the simultaneous-pulse rule applies;
  - event_count resets to 0.
- Undefined: event_count port and counters are absent; a second pulse on a pending input drops the press and raises overflow.

Test Plan:
- Reset, then pulse_in=4'b0010 at edge 5, event_ready=1 → event_valid=1 after edge 6 with event_id=1; event_valid=0 after edge 7; pending=0; overflow never set.
- Reset, pulse_in=4'b1111 on one edge, event_ready=1 → event_id sequence 0,1,2,3 on 4 consecutive cycles with event_valid continuously 1, then event_valid=0.
- event_ready=0 with pulses on buttons 2 then 0 → event_id=2 held stable ≥10 cycles; after ready, next event_id=0 (wrap from last_grant=2); pending shows 4'b0001 while waiting.
- Button 3 pending and not granted, second pulse_in[3] → overflow=1 for exactly 1 cycle, only one event with id 3 is delivered; with EVENT_COUNT_EN, no overflow and event_count=2.
- pulse_in[1] on the same edge that grants button 1 → after handshake a second event with id 1 follows and no overflow; EVENT_COUNT_EN, 8 pulses on button 0 while stalled (CNT_W=3) → event_count=7 and overflow pulses once.
- rst_s_n=0 while event_valid=1 and pending=4'b0110 → after that edge event_valid=0, pending=0; the next pulse_in=4'b0100 yields event_id=2 with 2-clock latency.
